// File: rtl/eq_cfg_pkg.sv
// -----------------------------------------------------------------------------
// eq_cfg_pkg
//   Shared definitions for the equalizer configuration-bus writer:
//   FSM state encoding, bus/gain widths, bytes per gain word, default base
//   address, and the band-to-address helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package eq_cfg_pkg;

  localparam int GAIN_W         = 24;
  localparam int BUS_W          = 8;
  localparam int BYTES_PER_GAIN = 3;
  localparam int DEF_ADDR_BASE  = 1;

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    DONE,
    ERR
  } state_t;

  // Address of byte 0 of a band. Deliberately computed in BUS_W bits so that
  // large band/base combinations wrap around the 8-bit register space.
  function automatic logic [BUS_W-1:0] band_base(input logic [BUS_W-1:0] band,
                                                 input int addr_base);
    logic [BUS_W-1:0] w_mul;
    w_mul = band * BUS_W'(BYTES_PER_GAIN);
    return w_mul + BUS_W'(addr_base);
  endfunction

endpackage

// File: rtl/eq_gain_clamp.sv
// -----------------------------------------------------------------------------
// eq_gain_clamp
//   Combinational saturator for a signed two's-complement gain word.
//   Output is limited to [-GAIN_LIMIT, +GAIN_LIMIT].
// Ports:
//   i_gain  in   GAIN_W  signed gain before saturation
//   o_gain  out  GAIN_W  signed gain after saturation
// -----------------------------------------------------------------------------
module eq_gain_clamp
  import eq_cfg_pkg::*;
#(
  parameter int GAIN_LIMIT = 16
) (
  input  logic [GAIN_W-1:0] i_gain,
  output logic [GAIN_W-1:0] o_gain
);

  localparam logic signed [GAIN_W-1:0] LP_HI = GAIN_W'(GAIN_LIMIT);
  localparam logic signed [GAIN_W-1:0] LP_LO = -LP_HI;

  function automatic logic signed [GAIN_W-1:0] sat_gain(input logic signed [GAIN_W-1:0] g);
    if (g > LP_HI) begin
      return LP_HI;
    end else if (g < LP_LO) begin
      return LP_LO;
    end
    return g;
  endfunction

  logic signed [GAIN_W-1:0] w_gain_s;

  assign w_gain_s = i_gain;
  assign o_gain   = sat_gain(w_gain_s);

endmodule

// File: rtl/eq_gain_writer.sv
// -----------------------------------------------------------------------------
// eq_gain_writer
//   Initiator of the equalizer byte-wide register write bus. Accepts one
//   24-bit signed band gain per command (valid/ready) and issues three byte
//   writes, LSB first, at addr = ADDR_BASE + 3*band + k (8-bit wrap).
//   Bands >= NUM_BANDS are dropped with a one-cycle err pulse.
//
// Optional feature: define EQ_GAIN_CLAMP_EN to saturate the captured gain to
//   [-GAIN_LIMIT, +GAIN_LIMIT] before the byte split (no latency change).
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous reset, active low
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   writer idle and able to accept
//   cmd_band   in   8   band index
//   cmd_gain   in   24  signed gain
//   we         out  1   write strobe
//   addr       out  8   write address
//   data_in    out  8   write data
//   busy       out  1   sequence in progress (B0..DONE, ERR)
//   done       out  1   one-cycle pulse at sequence end
//   err        out  1   one-cycle pulse, command rejected
// -----------------------------------------------------------------------------
module eq_gain_writer
  import eq_cfg_pkg::*;
#(
  parameter int NUM_BANDS  = 2,
  parameter int ADDR_BASE  = DEF_ADDR_BASE,
  parameter int GAIN_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_band,
  input  logic [23:0] cmd_gain,
  output logic        we,
  output logic [7:0]  addr,
  output logic [7:0]  data_in,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t                  r_state;
  logic [BUS_W-1:0]        r_base;
  // Byte 0 is emitted straight from the capture path, so only the upper
  // two bytes need to be held for B1/B2.
  logic [GAIN_W-1:BUS_W]   r_gain_hi;

  logic [GAIN_W-1:0]       w_gain;
  logic [BUS_W-1:0]        w_base;
  logic                    w_accept;
  logic                    w_band_ok;

`ifdef EQ_GAIN_CLAMP_EN
  eq_gain_clamp #(
    .GAIN_LIMIT (GAIN_LIMIT)
  ) u_clamp (
    .i_gain (cmd_gain),
    .o_gain (w_gain)
  );
`else
  assign w_gain = cmd_gain;
`endif

  assign cmd_ready = rst_n & (r_state == IDLE);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_band_ok = ({24'd0, cmd_band} < 32'(NUM_BANDS));
  assign w_base    = band_base(cmd_band, ADDR_BASE);

  // Control FSM and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      we      <= 1'b0;
      addr    <= '0;
      data_in <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            busy <= 1'b1;
            if (w_band_ok) begin
              // Byte 0 goes out on the same edge that captures the command.
              r_state <= B0;
              we      <= 1'b1;
              addr    <= w_base;
              data_in <= w_gain[BUS_W-1:0];
            end else begin
              r_state <= ERR;
              err     <= 1'b1;
            end
          end
        end
        B0: begin
          r_state <= B1;
          we      <= 1'b1;
          addr    <= r_base + 8'd1;
          data_in <= r_gain_hi[15:8];
        end
        B1: begin
          r_state <= B2;
          we      <= 1'b1;
          addr    <= r_base + 8'd2;
          data_in <= r_gain_hi[23:16];
        end
        B2: begin
          // addr/data_in keep the last written values through DONE.
          r_state <= DONE;
          done    <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        ERR: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Command capture; data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept && w_band_ok) begin
      r_base    <= w_base;
      r_gain_hi <= w_gain[GAIN_W-1:BUS_W];
    end
  end

endmodule

// File: tb/tb_eq_gain_writer.sv
`timescale 1ns/1ps
module tb_eq_gain_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_band = 8'd0;
  logic [23:0] cmd_gain = 24'd0;
  logic        we;
  logic [7:0]  addr;
  logic [7:0]  data_in;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  band;
    logic [23:0] gain;
    logic        exp_err;
    logic [7:0]  exp_addr0;
    logic [7:0]  exp_d0;
    logic [7:0]  exp_d1;
    logic [7:0]  exp_d2;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  eq_gain_writer #(
    .NUM_BANDS  (2),
    .ADDR_BASE  (1),
    .GAIN_LIMIT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_band  (cmd_band),
    .cmd_gain  (cmd_gain),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", addr, data_in);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, addr}, {24'd0, e.addr});
        chk("wr_data", {24'd0, data_in}, {24'd0, e.data});
      end
    end
  end

  // Wait (at negedges) until the writer is ready, bounded.
  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(name, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_band  = v.band;
    cmd_gain  = v.gain;
    wait_ready($sformatf("v%0d_ready", idx));
    if (!v.exp_err) begin
      push_wr(v.exp_addr0,        v.exp_d0);
      push_wr(v.exp_addr0 + 8'd1, v.exp_d1);
      push_wr(v.exp_addr0 + 8'd2, v.exp_d2);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_gain  = ~v.gain;
    cmd_band  = 8'hFF;
    if (v.exp_err) begin
      chk($sformatf("v%0d_err", idx),      {31'd0, err},       32'd1);
      chk($sformatf("v%0d_err_we", idx),   {31'd0, we},        32'd0);
      chk($sformatf("v%0d_err_busy", idx), {31'd0, busy},      32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_err_clr", idx),  {31'd0, err},       32'd0);
      chk($sformatf("v%0d_err_rdy", idx),  {31'd0, cmd_ready}, 32'd1);
      chk($sformatf("v%0d_err_we2", idx),  {31'd0, we},        32'd0);
    end else begin
      chk($sformatf("v%0d_b0_we", idx),   {31'd0, we},   32'd1);
      chk($sformatf("v%0d_b0_busy", idx), {31'd0, busy}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_b2_we", idx),   {31'd0, we},   32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_done", idx),    {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_done_we", idx), {31'd0, we},   32'd0);
      chk($sformatf("v%0d_done_busy", idx), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_hold_addr", idx), {24'd0, addr}, {24'd0, v.exp_addr0 + 8'd2});
      chk($sformatf("v%0d_hold_data", idx), {24'd0, data_in}, {24'd0, v.exp_d2});
      @(negedge clk);
      chk($sformatf("v%0d_done_clr", idx), {31'd0, done},      32'd0);
      chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy},     32'd0);
      chk($sformatf("v%0d_idle_rdy", idx), {31'd0, cmd_ready}, 32'd1);
    end
    chk($sformatf("v%0d_q_empty", idx), exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;

    vecs[0] = '{8'd0,   24'h000010, 1'b0, 8'd1, 8'h10, 8'h00, 8'h00};
    vecs[1] = '{8'd1,   24'hFFFFF0, 1'b0, 8'd4, 8'hF0, 8'hFF, 8'hFF};
    vecs[2] = '{8'd5,   24'h000123, 1'b1, 8'd0, 8'h00, 8'h00, 8'h00};
`ifdef EQ_GAIN_CLAMP_EN
    vecs[3] = '{8'd0,   24'h000064, 1'b0, 8'd1, 8'h10, 8'h00, 8'h00};
    vecs[4] = '{8'd1,   24'hFFFF9C, 1'b0, 8'd4, 8'hF0, 8'hFF, 8'hFF};
    vecs[6] = '{8'd1,   24'h123456, 1'b0, 8'd4, 8'h10, 8'h00, 8'h00};
    vecs[8] = '{8'd0,   24'h800000, 1'b0, 8'd1, 8'hF0, 8'hFF, 8'hFF};
`else
    vecs[3] = '{8'd0,   24'h000064, 1'b0, 8'd1, 8'h64, 8'h00, 8'h00};
    vecs[4] = '{8'd1,   24'hFFFF9C, 1'b0, 8'd4, 8'h9C, 8'hFF, 8'hFF};
    vecs[6] = '{8'd1,   24'h123456, 1'b0, 8'd4, 8'h56, 8'h34, 8'h12};
    vecs[8] = '{8'd0,   24'h800000, 1'b0, 8'd1, 8'h00, 8'h00, 8'h80};
`endif
    vecs[5] = '{8'd255, 24'h000001, 1'b1, 8'd0, 8'h00, 8'h00, 8'h00};
    vecs[7] = '{8'd2,   24'h000001, 1'b1, 8'd0, 8'h00, 8'h00, 8'h00};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we",    {31'd0, we},        32'd0);
    chk("rst_addr",  {24'd0, addr},      32'd0);
    chk("rst_data",  {24'd0, data_in},   32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_err",   {31'd0, err},       32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
    end

    // Two back-to-back commands with cmd_valid held high; the first one's
    // inputs are overwritten right after it is accepted.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_band  = 8'd0;
    cmd_gain  = 24'h0000AA;
    push_wr(8'd1, 8'hAA);
    push_wr(8'd2, 8'h00);
    push_wr(8'd3, 8'h00);
    push_wr(8'd4, 8'hBB);
    push_wr(8'd5, 8'hCC);
    push_wr(8'd6, 8'hDD);
    wait_ready("hold_ready1");
    @(negedge clk);
    cmd_band = 8'd1;
    cmd_gain = 24'hDDCCBB;
    n = 1;
    while (cmd_ready !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("hold_spacing", n, 32'd5);
    chk("hold_done_clr", {31'd0, done}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_b0_we", {31'd0, we}, 32'd1);
    repeat (5) @(negedge clk);
    chk("hold_q_empty", exp_q.size(), 32'd0);
    chk("hold_idle_rdy", {31'd0, cmd_ready}, 32'd1);

    // Reset while in B1: B2 must never be written.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_band  = 8'd1;
    cmd_gain  = 24'h778899;
    push_wr(8'd4, 8'h99);
    push_wr(8'd5, 8'h88);
    wait_ready("mid_rst_ready");
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_b1_we", {31'd0, we}, 32'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_we",    {31'd0, we},        32'd0);
    chk("mid_rst_busy",  {31'd0, busy},      32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_addr",  {24'd0, addr},      32'd0);
    @(negedge clk);
    chk("mid_rst_we2",   {31'd0, we},        32'd0);
    chk("mid_rst_q",     exp_q.size(),       32'd0);
    rst_n = 1'b1;
    v = '{8'd0, 24'h00ABCD, 1'b0, 8'd1, 8'hCD, 8'hAB, 8'h00};
    run_vec(100, v);

    chk("final_q_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
